alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

- Initiator-side front end for the 16-bit registered ALU.
- Accepts operation requests on a valid/ready input, buffers them in a small FIFO, and drives the ALU's opcode/A/B inputs one operation at a time.
- Captures the ALU result after the fixed ALU latency and returns it on a valid/ready output.
- Sits between the control path and the ALU, so no upstream logic needs to track ALU timing.

## Interface
- WIDTH, 16, operand and result width; must match the ALU.
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- ALU_LATENCY, 1, clock edges from ALU sampling its inputs to result valid; at least 1.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request FIFO not full.
- in_opcode  in  4  ALU opcode.
- in_a, in_b  in  WIDTH  operands.
- in_chain  in  1  present only with ALU_SEQ_CHAIN_EN; see Configuration.
- out_valid  out  1  response valid.
- out_ready  in  1  response accepted.
- out_result  out  WIDTH  captured ALU result, or 0 on error.
- out_err  out  1  request had an unsupported opcode.
- alu_opcode  out  4  to ALU.
- alu_a, alu_b  out  WIDTH  to ALU.
- alu_result  in  WIDTH  from ALU.
- busy  out  1  FSM not IDLE or FIFO non-empty.

## Operation
- **Supported opcodes:** 0001 RESET, 0010 ADD, 0100 SUB, 0101 AND, 1000 OR, 1001 XOR, 1010 NAND, 1011 NOR, 1101 NOT.
- **Rejected opcodes:** all others, including 0000. A rejected request is never issued to the ALU; it produces a response with out_err=1 and out_result=0.
- **Request FIFO:**
  - A push occurs when in_valid && in_ready.
  - in_ready = !full, evaluated from the current occupancy only. A pop in the same cycle does not free a slot for a push while the FIFO is full.
  - Pointers wrap modulo DEPTH. An occupancy count of width log2(DEPTH)+1 distinguishes full from empty.
- **FSM states:** IDLE, WAIT, RESP.
  - **IDLE:** if the FIFO is non-empty, pop the head at the next edge.
    - Supported opcode: load alu_opcode/alu_a/alu_b, load wait counter = ALU_LATENCY, go to WAIT.
    - Rejected opcode: go to RESP with out_err=1.
  - **WAIT:** decrement the counter each edge. At the edge where the counter equals 0:
    - capture alu_result into out_result;
    - set out_err=0 and out_valid=1;
    - drive alu_opcode to 4'b0000;
    - go to RESP.
  - **RESP:** hold out_valid and the data stable until out_ready. On the handshake edge:
    - if the FIFO is non-empty, pop and load the next request directly, with the same decisions as IDLE;
    - otherwise go to IDLE and clear out_valid.
- alu_a and alu_b hold their last values when not issuing. alu_opcode is non-zero only from the load edge to the capture edge.

## Timing
- **Reset values:**
  - in_ready=1, out_valid=0, out_err=0, busy=0;
  - out_result=0, alu_opcode=0, alu_a=0, alu_b=0;
  - FIFO empty, FSM in IDLE, wait counter=0, chain register=0.
- **Reset mid-operation:** asserting rst_n low discards queued and in-flight requests immediately. No response is produced for them.
- **Load-to-capture:** ALU inputs are loaded at edge L. The ALU samples them at L+1, and alu_result is captured at L+ALU_LATENCY+1.
- **Empty-system latency (ALU_LATENCY=1):** request accepted at edge E0, popped/loaded at E1, captured at E3; out_valid is high after E3.
- **Rejected-opcode latency:** out_valid is high after E1.
- **Throughput:** with out_ready held high, one supported op completes every ALU_LATENCY+2 cycles.
- **Simultaneous events:**
  - A push in the same cycle as a pop of the last entry is legal; the count is unchanged.
  - A push into an empty FIFO is not visible to IDLE until the following edge.

## Configuration
- **ALU_SEQ_CHAIN_EN defined:**
  - The in_chain port exists and is stored per FIFO entry.
  - When in_chain=1, the issued alu_b is the chain register instead of the stored in_b.
  - The chain register loads out_result on every successful capture, i.e. out_err=0.
  - An ALU RESET op sets the chain register to 0.
- **ALU_SEQ_CHAIN_EN undefined:** the in_chain port, the chain register and its storage are absent; alu_b always comes from in_b.

## Test plan
- Reset, then one ADD request with A=16'h0003, B=16'h0004 -> out_valid 3 cycles after acceptance, out_result=16'h0007, out_err=0, alu_opcode back to 0000.
- Four back-to-back requests with out_ready=1: SUB 10-3, AND FFFF&00F0, NOT A=0000, RESET -> in-order results 0007, 00F0, FFFF, 0000; in_ready drops only when 4 entries are queued.
- Request with opcode 0011 -> response one cycle after pop, out_err=1, out_result=0, alu_opcode never leaves 0000.
- Hold out_ready=0 for 10 cycles with a response pending -> out_valid and out_result stable; queued requests are not issued until the handshake.
- Assert rst_n low while in WAIT with 3 requests queued -> all outputs at reset values immediately; no responses follow after reset release.
- With ALU_SEQ_CHAIN_EN: ADD 5+1, then ADD A=2 with in_chain=1 -> results 0006 and 0008.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, response and ALU-side signals of the sequencer.
// in_chain exists only when ALU_SEQ_CHAIN_EN is defined.
interface alu_op_sequencer_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
`ifdef ALU_SEQ_CHAIN_EN
  logic             in_chain;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             busy;
  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready, alu_result,
`ifdef ALU_SEQ_CHAIN_EN
    output in_chain,
`endif
    input  in_ready, out_valid, out_result, out_err, alu_opcode, alu_a, alu_b, busy
  );
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready, alu_result,
`ifdef ALU_SEQ_CHAIN_EN
    input  in_chain,
`endif
    output in_ready, out_valid, out_result, out_err, alu_opcode, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU requests, issues them one at a time to a registered ALU and returns results.
// Defining ALU_SEQ_CHAIN_EN adds per-request chaining of the previous result into alu_b.
module alu_op_sequencer #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 1
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ALU_LATENCY + 1);
  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef ALU_SEQ_CHAIN_EN
    logic             chain;
`endif
  } entry_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  entry_t           mem_q [DEPTH];
  entry_t           head;
  entry_t           entry;
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  state_t           state_q, state_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic             out_valid_q, out_valid_d;
  logic             out_err_q, out_err_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             push, pop, empty, sup;
`ifdef ALU_SEQ_CHAIN_EN
  logic [WIDTH-1:0] chain_q, chain_d;
  assign entry = {bus.in_opcode, bus.in_a, bus.in_b, bus.in_chain};
`else
  assign entry = {bus.in_opcode, bus.in_a, bus.in_b};
`endif
  assign head  = mem_q[rd_q];
  assign empty = cnt_q == '0;
  assign sup   = head.op inside {4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000,
                                 4'b1001, 4'b1010, 4'b1011, 4'b1101};
  // full is judged on current occupancy only, so a same-cycle pop never admits a push
  assign bus.in_ready   = cnt_q != (AW+1)'(DEPTH);
  assign push           = bus.in_valid && bus.in_ready;
  assign bus.busy       = state_q != IDLE || !empty;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_result = out_result_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= entry;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      wait_q       <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_result_q <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q      <= '0;
`endif
    end else begin
      wr_q         <= wr_q + AW'(push);
      rd_q         <= rd_q + AW'(pop);
      cnt_q        <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      state_q      <= state_d;
      wait_q       <= wait_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      out_result_q <= out_result_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q      <= chain_d;
`endif
    end
  end
  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE:    pop = !empty;
      WAIT:    state_d = wait_q == '0 ? RESP : WAIT;
      RESP: begin
        pop     = bus.out_ready && !empty;
        state_d = bus.out_ready ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
    if (pop) state_d = sup ? WAIT : RESP;
  end
  always_comb begin
    wait_d       = wait_q;
    out_valid_d  = out_valid_q;
    out_err_d    = out_err_q;
    out_result_d = out_result_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
`ifdef ALU_SEQ_CHAIN_EN
    chain_d      = chain_q;
`endif
    if (state_q == WAIT && wait_q != '0) wait_d = wait_q - CW'(1);
    if (state_q == WAIT && wait_q == '0) begin
      out_valid_d  = 1'b1;
      out_err_d    = 1'b0;
      out_result_d = bus.alu_result;
      alu_opcode_d = '0;
`ifdef ALU_SEQ_CHAIN_EN
      chain_d      = alu_opcode_q == 4'b0001 ? '0 : bus.alu_result;
`endif
    end
    if (state_q == RESP && bus.out_ready) out_valid_d = 1'b0;
    if (pop && sup) begin
      alu_opcode_d = head.op;
      alu_a_d      = head.a;
`ifdef ALU_SEQ_CHAIN_EN
      alu_b_d      = head.chain ? chain_q : head.b;
`else
      alu_b_d      = head.b;
`endif
      wait_d       = CW'(ALU_LATENCY);
    end
    if (pop && !sup) begin
      out_valid_d  = 1'b1;
      out_err_d    = 1'b1;
      out_result_d = '0;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized self-checking bench with a behavioural ALU and an in-order response model.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  localparam int W = 16;
  typedef struct {
    logic         err;
    logic [W-1:0] res;
  } resp_t;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  resp_t exp_q[$];
  resp_t got_q[$];
  resp_t mresp;
  logic [W-1:0] m_chain = '0;
  logic [W-1:0] mb;
  logic [3:0] sup_ops [9] = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD};
  logic [3:0] bb_op   [4] = '{4'h4, 4'h5, 4'hD, 4'h1};
  logic [W-1:0] bb_a  [4] = '{16'd10, 16'hFFFF, 16'h0000, 16'h1234};
  logic [W-1:0] bb_b  [4] = '{16'd3, 16'h00F0, 16'h5555, 16'h4321};
  logic [W-1:0] bb_want [4] = '{16'h0007, 16'h00F0, 16'hFFFF, 16'h0000};

  alu_op_sequencer_if #(.WIDTH(W)) bus ();
  alu_op_sequencer #(.WIDTH(W), .DEPTH(4), .ALU_LATENCY(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      4'h2:    return a + b;
      4'h4:    return a - b;
      4'h5:    return a & b;
      4'h8:    return a | b;
      4'h9:    return a ^ b;
      4'hA:    return ~(a & b);
      4'hB:    return ~(a | b);
      4'hD:    return ~a;
      default: return '0;
    endcase
  endfunction

  function automatic logic is_sup(logic [3:0] op);
    return op inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD};
  endfunction

  // registered ALU, one edge from sampling to result
  always @(posedge clk) bus.alu_result <= alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);

  // expected responses are fixed at acceptance; observed ones are logged at each output handshake
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      got_q.delete();
      m_chain = '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        mresp.err = bus.out_err;
        mresp.res = bus.out_result;
        got_q.push_back(mresp);
      end
      if (bus.in_valid && bus.in_ready) begin
`ifdef ALU_SEQ_CHAIN_EN
        mb = bus.in_chain ? m_chain : bus.in_b;
`else
        mb = bus.in_b;
`endif
        mresp.err = !is_sup(bus.in_opcode);
        mresp.res = mresp.err ? '0 : alu_f(bus.in_opcode, bus.in_a, mb);
        if (!mresp.err) m_chain = mresp.res;
        exp_q.push_back(mresp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
  endtask

  task automatic drain();
    put(1'b0, 4'h0, '0, '0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 200 && (bus.busy || bus.out_valid); c++) tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    put(1'b0, 4'h0, '0, '0);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_err, bus.busy, bus.alu_opcode} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 10000000", {bus.in_ready, bus.out_valid, bus.out_err, bus.busy, bus.alu_opcode});
    end
    n_cmp++;
    if ({bus.out_result, bus.alu_a, bus.alu_b} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_data: got result=%h a=%h b=%h want all 0", bus.out_result, bus.alu_a, bus.alu_b);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got in_ready=%b busy=%b want 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_add();
    bus.out_ready = 1'b0;
    put(1'b1, 4'h2, 16'h0003, 16'h0004);
    tick();
    put(1'b0, 4'h0, '0, '0);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.alu_opcode !== 4'h0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL add_e0: got valid=%b op=%h busy=%b want 0 0 1", bus.out_valid, bus.alu_opcode, bus.busy);
    end
    tick();
    n_cmp++;
    if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== {4'h2, 16'h0003, 16'h0004}) begin
      n_bad++;
      $display("FAIL add_load: got op=%h a=%h b=%h want 2 0003 0004", bus.alu_opcode, bus.alu_a, bus.alu_b);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL add_e2_valid: got %b want 0", bus.out_valid);
    end
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.out_err, bus.out_result, bus.alu_opcode} !== {1'b1, 1'b0, 16'h0007, 4'h0}) begin
      n_bad++;
      $display("FAIL add_result: got valid=%b err=%b res=%h op=%h want 1 0 0007 0", bus.out_valid, bus.out_err, bus.out_result, bus.alu_opcode);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL add_handshake: got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int got = 0;
    logic rdy_ok = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 4; c++) begin
      if (k < 4) put(1'b1, bb_op[k], bb_a[k], bb_b[k]);
      else put(1'b0, 4'h0, '0, '0);
      if (!bus.in_ready) rdy_ok = 1'b0;
      if (bus.out_valid) begin
        n_cmp++;
        if ({bus.out_err, bus.out_result} !== {1'b0, bb_want[got]}) begin
          n_bad++;
          $display("FAIL b2b_result%0d: got err=%b res=%h want 0 %h", got, bus.out_err, bus.out_result, bb_want[got]);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) k++;
      tick();
    end
    n_cmp++;
    if (got != 4) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d responses want 4", got);
    end
    n_cmp++;
    if (!rdy_ok) begin
      n_bad++;
      $display("FAIL b2b_in_ready: got a low in_ready want always 1");
    end
    drain();
  endtask

  task automatic test_reject();
    logic op_ok = 1'b1;
    bus.out_ready = 1'b0;
    put(1'b1, 4'h3, 16'($urandom), 16'($urandom));
    tick();
    put(1'b0, 4'h0, '0, '0);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.alu_opcode !== 4'h0) begin
      n_bad++;
      $display("FAIL reject_e0: got valid=%b op=%h want 0 0", bus.out_valid, bus.alu_opcode);
    end
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.out_err, bus.out_result} !== {1'b1, 1'b1, 16'h0}) begin
      n_bad++;
      $display("FAIL reject_resp: got valid=%b err=%b res=%h want 1 1 0000", bus.out_valid, bus.out_err, bus.out_result);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.alu_opcode !== 4'h0) op_ok = 1'b0;
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (!op_ok || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reject_quiet: got op_ok=%b valid=%b busy=%b want 1 0 0", op_ok, bus.out_valid, bus.busy);
    end
    put(1'b1, 4'h0, 16'($urandom), 16'($urandom));
    tick();
    put(1'b0, 4'h0, '0, '0);
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.out_err, bus.out_result, bus.alu_opcode} !== {1'b1, 1'b1, 16'h0, 4'h0}) begin
      n_bad++;
      $display("FAIL reject_zero: got valid=%b err=%b res=%h op=%h want 1 1 0000 0", bus.out_valid, bus.out_err, bus.out_result, bus.alu_opcode);
    end
    drain();
  endtask

  task automatic test_fill();
    int acc = 0;
    int eb = exp_q.size();
    int gb = got_q.size();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      put(1'b1, sup_ops[$urandom_range(0, 8)], 16'($urandom), 16'($urandom));
      if (bus.in_ready) acc++;
      tick();
    end
    n_cmp++;
    if (acc != 5 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_level: got accepted=%0d in_ready=%b busy=%b want 5 0 1", acc, bus.in_ready, bus.busy);
    end
    bus.out_ready = 1'b1;
    put(1'b1, 4'h2, 16'($urandom), 16'($urandom));
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_pop_no_free: got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    put(1'b0, 4'h0, '0, '0);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_after_pop: got in_ready=%b want 1", bus.in_ready);
    end
    drain();
    n_cmp++;
    if (got_q.size() - gb != 5 || exp_q.size() - eb != 5) begin
      n_bad++;
      $display("FAIL fill_count: got %0d responses %0d accepted want 5 5", got_q.size() - gb, exp_q.size() - eb);
    end
    for (int i = 0; i < 5 && gb + i < got_q.size() && eb + i < exp_q.size(); i++) begin
      n_cmp++;
      if ({got_q[gb+i].err, got_q[gb+i].res} !== {exp_q[eb+i].err, exp_q[eb+i].res}) begin
        n_bad++;
        $display("FAIL fill_resp%0d: got err=%b res=%h want %b %h", i, got_q[gb+i].err, got_q[gb+i].res, exp_q[eb+i].err, exp_q[eb+i].res);
      end
    end
  endtask

  task automatic test_stall();
    int eb = exp_q.size();
    int gb = got_q.size();
    logic stable = 1'b1;
    logic [W-1:0] r0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, sup_ops[$urandom_range(1, 8)], 16'($urandom), 16'($urandom));
      tick();
    end
    put(1'b0, 4'h0, '0, '0);
    for (int c = 0; c < 10 && !bus.out_valid; c++) tick();
    r0 = bus.out_result;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || exp_q.size() <= eb || r0 !== exp_q[eb].res) begin
      n_bad++;
      $display("FAIL stall_first: got valid=%b res=%h want 1 and model value", bus.out_valid, r0);
    end
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid !== 1'b1 || bus.out_result !== r0 || bus.alu_opcode !== 4'h0) stable = 1'b0;
      tick();
    end
    n_cmp++;
    if (!stable) begin
      n_bad++;
      $display("FAIL stall_hold: got output change or new issue during stall want none");
    end
    drain();
    n_cmp++;
    if (got_q.size() - gb != 3) begin
      n_bad++;
      $display("FAIL stall_count: got %0d responses want 3", got_q.size() - gb);
    end
    for (int i = 0; i < 3 && gb + i < got_q.size() && eb + i < exp_q.size(); i++) begin
      n_cmp++;
      if ({got_q[gb+i].err, got_q[gb+i].res} !== {exp_q[eb+i].err, exp_q[eb+i].res}) begin
        n_bad++;
        $display("FAIL stall_resp%0d: got err=%b res=%h want %b %h", i, got_q[gb+i].err, got_q[gb+i].res, exp_q[eb+i].err, exp_q[eb+i].res);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ops [5];
    int seen = 0;
    for (int i = 0; i < 5; i++) ops[i] = sup_ops[$urandom_range(1, 8)];
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, ops[i], 16'($urandom), 16'($urandom));
      tick();
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pre_valid: got %b want 1", bus.out_valid);
    end
    bus.out_ready = 1'b1;
    put(1'b1, ops[4], 16'($urandom), 16'($urandom));
    tick();
    put(1'b0, 4'h0, '0, '0);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.alu_opcode !== ops[1] || bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_wait: got op=%h busy=%b in_ready=%b want %h 1 1", bus.alu_opcode, bus.busy, bus.in_ready, ops[1]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_err, bus.busy, bus.alu_opcode} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL rstmid_flags: got %b want 10000000", {bus.in_ready, bus.out_valid, bus.out_err, bus.busy, bus.alu_opcode});
    end
    n_cmp++;
    if ({bus.out_result, bus.alu_a, bus.alu_b} !== 48'h0) begin
      n_bad++;
      $display("FAIL rstmid_data: got result=%h a=%h b=%h want all 0", bus.out_result, bus.alu_a, bus.alu_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    n_cmp++;
    if (seen != 0 || got_q.size() != 0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_no_resp: got valid_cycles=%0d responses=%0d busy=%b want 0 0 0", seen, got_q.size(), bus.busy);
    end
  endtask

`ifdef ALU_SEQ_CHAIN_EN
  task automatic test_chain();
    int gb = got_q.size();
    bus.out_ready = 1'b0;
    bus.in_chain = 1'b0;
    put(1'b1, 4'h2, 16'd5, 16'd1);
    tick();
    bus.in_chain = 1'b1;
    put(1'b1, 4'h2, 16'd2, 16'($urandom));
    tick();
    bus.in_chain = 1'b0;
    drain();
    n_cmp++;
    if (got_q.size() < gb + 1 || got_q[gb].res !== 16'h0006) begin
      n_bad++;
      $display("FAIL chain_first: got %0d responses, want result 0006");
    end
    n_cmp++;
    if (got_q.size() < gb + 2 || got_q[gb+1].res !== 16'h0008 || got_q[gb+1].err !== 1'b0) begin
      n_bad++;
      $display("FAIL chain_second: got %0d responses, want result 0008", got_q.size() - gb);
    end
  endtask
`endif

  task automatic test_random();
    int eb = exp_q.size();
    int gb = got_q.size();
    int bad0 = n_bad;
    for (int c = 0; c < 400; c++) begin
      put($urandom_range(0, 2) != 0,
          $urandom_range(0, 6) == 0 ? 4'($urandom) : sup_ops[$urandom_range(0, 8)],
          16'($urandom), 16'($urandom));
`ifdef ALU_SEQ_CHAIN_EN
      bus.in_chain = 1'($urandom_range(0, 1));
`endif
      bus.out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    drain();
    n_cmp++;
    if (bus.busy !== 1'b0 || got_q.size() - gb != exp_q.size() - eb) begin
      n_bad++;
      $display("FAIL random_count: got %0d responses for %0d accepted, busy=%b", got_q.size() - gb, exp_q.size() - eb, bus.busy);
    end
    for (int i = 0; eb + i < exp_q.size() && gb + i < got_q.size(); i++) begin
      n_cmp++;
      if ({got_q[gb+i].err, got_q[gb+i].res} !== {exp_q[eb+i].err, exp_q[eb+i].res}) begin
        n_bad++;
        if (n_bad - bad0 < 10)
          $display("FAIL random_resp%0d: got err=%b res=%h want %b %h", i, got_q[gb+i].err, got_q[gb+i].res, exp_q[eb+i].err, exp_q[eb+i].res);
      end
    end
  endtask

  initial begin
    put(1'b0, 4'h0, '0, '0);
    bus.out_ready = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    bus.in_chain = 1'b0;
`endif
    test_reset();
    test_add();
    test_back_to_back();
    test_reject();
    test_fill();
    test_stall();
    test_reset_mid();
`ifdef ALU_SEQ_CHAIN_EN
    test_chain();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish within 500us");
    $fatal(1);
  end
endmodule
